// File: rtl/ic_cpu_bus_arbiter_if.sv
// ic_cpu_bus_arbiter_if: one CPU bus request/response channel
interface ic_cpu_bus_arbiter_if;
  logic        req;
  logic        gnt;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        recv;
  logic        ack;
  logic        error;
  logic [31:0] rdata;
  modport master (output req, wen, strb, wdata, addr, ack, input gnt, recv, error, rdata);
  modport slave  (input req, wen, strb, wdata, addr, ack, output gnt, recv, error, rdata);
endinterface

// File: rtl/ic_cpu_bus_arbiter.sv
// ic_cpu_bus_arbiter: round-robin 2:1 CPU bus arbiter with in-order response steering
module ic_cpu_bus_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  ic_cpu_bus_arbiter_if.slave  m0,
  ic_cpu_bus_arbiter_if.slave  m1,
  ic_cpu_bus_arbiter_if.master s,
  output logic                 rsp_orphan
);
  localparam int AW = $clog2(DEPTH);
  logic             last_q, last_d, orphan_q, orphan_d;
  logic [DEPTH-1:0] ids_q, ids_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, sel, push, pop, busy, head;
  // Select a master without looking at s.gnt, steer responses by FIFO head, compute next state
  always_comb begin
    full = count_q == (AW+1)'(DEPTH);
    sel = (m0.req & m1.req) ? ~last_q : m1.req;
    s.req = (m0.req | m1.req) & ~full;
    s.wen = sel ? m1.wen : m0.wen;
    s.strb = sel ? m1.strb : m0.strb;
    s.wdata = sel ? m1.wdata : m0.wdata;
    s.addr = sel ? m1.addr : m0.addr;
    push = s.req & s.gnt;
    m0.gnt = push & ~sel;
    m1.gnt = push & sel;
    busy = count_q != '0;
    head = ids_q[rptr_q];
    m0.recv = s.recv & busy & ~head;
    m1.recv = s.recv & busy & head;
    m0.rdata = s.rdata;
    m1.rdata = s.rdata;
    m0.error = s.error;
    m1.error = s.error;
    s.ack = busy ? (head ? m1.ack : m0.ack) : s.recv;
    pop = s.recv & s.ack & busy;
    ids_d = ids_q;
    if (push) ids_d[wptr_q] = sel;
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    last_d = push ? sel : last_q;
    orphan_d = s.recv & ~busy;
  end
  // Priority, ID FIFO and orphan flag registers; last resets to 1 so master 0 wins the first tie
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      last_q <= 1'b1;
      orphan_q <= 1'b0;
      ids_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      last_q <= last_d;
      orphan_q <= orphan_d;
      ids_q <= ids_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  assign rsp_orphan = orphan_q;
endmodule

// File: tb/tb_ic_cpu_bus_arbiter.sv
// tb_ic_cpu_bus_arbiter: vector table, corner sequences and random traffic against a queue model
module tb_ic_cpu_bus_arbiter;
  localparam int DEPTH = 4;
  logic g_clk = 1'b0;
  logic g_reset = 1'b1;
  logic rsp_orphan;
  ic_cpu_bus_arbiter_if m0_if ();
  ic_cpu_bus_arbiter_if m1_if ();
  ic_cpu_bus_arbiter_if s_if ();
  ic_cpu_bus_arbiter #(.DEPTH(DEPTH)) dut (
    .g_clk(g_clk),
    .g_reset(g_reset),
    .m0(m0_if),
    .m1(m1_if),
    .s(s_if),
    .rsp_orphan(rsp_orphan)
  );
  always #5 g_clk = ~g_clk;
  int n_chk = 0;
  int n_pass = 0;
  int q[$];
  bit last_m = 1'b1;
  bit orph_m = 1'b0;
  typedef struct {
    logic r0, r1, sg, sr, a0, a1;
    logic [31:0] rd;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[21];
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic step(input logic r0, r1, sg, sr, a0, a1, rs, input logic [31:0] rd,
                      output logic [6:0] act);
    logic full, w, sreq, ne, h, sack;
    logic [6:0] exp7;
    logic [68:0] f0, f1;
    logic [32:0] rsp;
    g_reset = rs;
    m0_if.req = r0;
    m1_if.req = r1;
    s_if.gnt = sg;
    s_if.recv = sr;
    m0_if.ack = a0;
    m1_if.ack = a1;
    m0_if.wen = 1'($urandom);
    m0_if.strb = 4'($urandom);
    m0_if.wdata = $urandom;
    m0_if.addr = $urandom;
    m1_if.wen = 1'($urandom);
    m1_if.strb = 4'($urandom);
    m1_if.wdata = $urandom;
    m1_if.addr = (r1 && !r0) ? 32'h100 : $urandom;
    s_if.rdata = (rd != 0) ? rd : $urandom;
    s_if.error = 1'($urandom);
    f0 = {m0_if.wen, m0_if.strb, m0_if.wdata, m0_if.addr};
    f1 = {m1_if.wen, m1_if.strb, m1_if.wdata, m1_if.addr};
    rsp = {s_if.error, s_if.rdata};
    #2;
    full = q.size() == DEPTH;
    w = (r0 & r1) ? !last_m : r1;
    sreq = (r0 | r1) & !full;
    ne = q.size() != 0;
    h = ne && q[0] == 1;
    sack = ne ? (h ? a1 : a0) : sr;
    exp7 = {sreq & sg & !w, sreq & sg & w, sreq, sr & ne & !h, sr & ne & h, sack, orph_m};
    act = {m0_if.gnt, m1_if.gnt, s_if.req, m0_if.recv, m1_if.recv, s_if.ack, rsp_orphan};
    chk("ctrl", 96'(act), 96'(exp7));
    chk("s_fields", 96'({s_if.wen, s_if.strb, s_if.wdata, s_if.addr}), 96'(w ? f1 : f0));
    chk("m0_rsp", 96'({m0_if.error, m0_if.rdata}), 96'(rsp));
    chk("m1_rsp", 96'({m1_if.error, m1_if.rdata}), 96'(rsp));
    @(posedge g_clk);
    if (rs) begin
      q.delete();
      last_m = 1'b1;
      orph_m = 1'b0;
    end else begin
      orph_m = sr & !ne;
      if (sr & sack & ne) void'(q.pop_front());
      if (sreq & sg) begin
        q.push_back(int'(w));
        last_m = w;
      end
    end
    #1;
  endtask
  initial begin
    logic [6:0] a;
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 32'h0, 7'b0000000};
    tbl[1]  = '{0, 1, 1, 0, 0, 0, 32'h0, 7'b0110000};
    tbl[2]  = '{0, 0, 0, 1, 0, 1, 32'hDEADBEEF, 7'b0000110};
    tbl[3]  = '{1, 1, 1, 0, 0, 0, 32'h0, 7'b1010000};
    tbl[4]  = '{1, 1, 1, 0, 0, 0, 32'h0, 7'b0110000};
    tbl[5]  = '{1, 1, 1, 0, 0, 0, 32'h0, 7'b1010000};
    tbl[6]  = '{1, 1, 1, 0, 0, 0, 32'h0, 7'b0110000};
    tbl[7]  = '{1, 1, 1, 0, 0, 0, 32'h0, 7'b0000000};
    tbl[8]  = '{1, 1, 1, 1, 1, 0, 32'h0, 7'b0001010};
    tbl[9]  = '{1, 1, 1, 0, 0, 0, 32'h0, 7'b1010000};
    tbl[10] = '{0, 0, 0, 1, 1, 0, 32'h0, 7'b0000100};
    tbl[11] = '{0, 0, 0, 1, 0, 1, 32'h0, 7'b0000110};
    tbl[12] = '{0, 0, 0, 1, 1, 0, 32'h0, 7'b0001010};
    tbl[13] = '{0, 0, 0, 1, 0, 1, 32'h0, 7'b0000110};
    tbl[14] = '{0, 0, 0, 1, 1, 0, 32'h0, 7'b0001010};
    tbl[15] = '{0, 0, 0, 1, 0, 0, 32'h0, 7'b0000010};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 32'h0, 7'b0000001};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 32'h0, 7'b0000000};
    tbl[18] = '{1, 1, 0, 0, 0, 0, 32'h0, 7'b0010000};
    tbl[19] = '{1, 1, 1, 0, 0, 0, 32'h0, 7'b0110000};
    tbl[20] = '{0, 0, 0, 1, 0, 1, 32'h0, 7'b0000110};
    {m0_if.req, m1_if.req, s_if.gnt, s_if.recv, m0_if.ack, m1_if.ack} = '0;
    {m0_if.wen, m0_if.strb, m0_if.wdata, m0_if.addr} = '0;
    {m1_if.wen, m1_if.strb, m1_if.wdata, m1_if.addr} = '0;
    {s_if.error, s_if.rdata} = '0;
    g_reset = 1'b1;
    repeat (2) @(posedge g_clk);
    #1;
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r0, tbl[i].r1, tbl[i].sg, tbl[i].sr, tbl[i].a0, tbl[i].a1, 1'b0, tbl[i].rd, a);
      chk($sformatf("vec%0d", i), 96'(a), 96'(tbl[i].exp));
      if (tbl[i].rd != 0) chk($sformatf("vec%0d_rdata", i), 96'(m1_if.rdata), 96'(tbl[i].rd));
    end
    step(1, 0, 1, 0, 0, 0, 0, 0, a);
    step(1, 0, 1, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 1, 0, a);
    step(0, 0, 0, 1, 0, 0, 0, 0, a);
    chk("rst_stale_rsp", 96'(a), 96'(7'b0000010));
    step(1, 1, 1, 0, 0, 0, 0, 0, a);
    chk("rst_tie_m0", 96'(a), 96'(7'b1010001));
    step(1, 1, 1, 0, 0, 0, 0, 0, a);
    chk("rst_tie_m1", 96'(a), 96'(7'b0110000));
    step(0, 0, 0, 1, 1, 1, 0, 0, a);
    step(0, 0, 0, 1, 1, 1, 0, 0, a);
    step(1, 0, 1, 0, 0, 0, 0, 0, a);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 1, 1, 0, 0, 0, a);
      chk($sformatf("wrap%0d", i), 96'(a), 96'(7'b1011010));
    end
    step(0, 0, 0, 1, 1, 0, 0, 0, a);
    chk("wrap_drain", 96'(a), 96'(7'b0001010));
    for (int i = 0; i < 600; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 49) == 0, 0, a);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ic_cpu_bus_arbiter.md
# ic_cpu_bus_arbiter

Two-to-one arbiter merging the CPU core's instruction and data request/response channels onto the single request/response channel consumed by the CPU-bus-to-BRAM bridge. Requests are granted round-robin, at most one per cycle. A small in-order ID FIFO records which master owns each outstanding request, so that responses from the downstream channel are steered back to the correct master. Request and response paths are combinational pass-throughs; only the arbitration priority and the ID FIFO are registered.

## Interface
- `DEPTH`, default 4: maximum outstanding (granted, unresponded) transactions; power of two, ≥2.
- `g_clk` input 1: clock; all state updates on the rising edge.
- `g_reset` input 1: reset; synchronous, active-high.
- `m0_req`/`m1_req` input 1: master 0 (instruction) / master 1 (data) request.
- `m0_gnt`/`m1_gnt` output 1: request accepted this cycle.
- `m0_wen`/`m1_wen` input 1: write enable.
- `m0_strb`/`m1_strb` input 4: write strobe.
- `m0_wdata`/`m1_wdata` input 32: write data.
- `m0_addr`/`m1_addr` input 32: address.
- `m0_recv`/`m1_recv` output 1: response valid to that master.
- `m0_ack`/`m1_ack` input 1: master accepts the response.
- `m0_error`/`m1_error` output 1: response error.
- `m0_rdata`/`m1_rdata` output 32: response read data.
- `s_req` output 1: downstream request.
- `s_gnt` input 1: downstream accepts the request.
- `s_wen` output 1, `s_strb` output 4, `s_wdata` output 32, `s_addr` output 32: downstream request fields.
- `s_recv` input 1: downstream response valid.
- `s_ack` output 1: response accepted.
- `s_error` input 1, `s_rdata` input 32: downstream response fields.
- `rsp_orphan` output 1: registered one-cycle pulse, asserted when a response arrived with no outstanding transaction.

## Operation
- State:
  - `last` (1 bit): last granted master.
  - ID FIFO: `DEPTH` entries of 1 bit, with write pointer, read pointer and `count` (log2(DEPTH)+1 bits).
- Selection (combinational; must not depend on `s_gnt`, which avoids a combinational loop with the bridge's stall path):
  - `sel` = the requesting master if only one requests.
  - If both request, `sel` = the master that is not `last`.
- `full` = (`count` == `DEPTH`). While full: `s_req` = 0 and `m0_gnt` = `m1_gnt` = 0.
- Request path:
  - `s_req` = (`m0_req` | `m1_req`) & !`full`.
  - `s_wen`/`s_strb`/`s_wdata`/`s_addr` = the fields of master `sel`.
  - When no master requests, the fields show master 0's.
- Grant: `mX_gnt` = `s_req` & `s_gnt` & (`sel` == X). The non-selected master's gnt is 0 and it keeps holding its request.
- Push: on `s_req` & `s_gnt`, write `sel` into the FIFO and set `last` <= `sel`.
- Response routing, by FIFO head ID `h`, valid when `count` != 0:
  - `mh_recv` = `s_recv`; the other master's recv = 0.
  - `mX_rdata` = `s_rdata` and `mX_error` = `s_error` for both masters (qualified by recv).
  - `s_ack` = `mh_ack`.
- Pop: on `s_recv` & `s_ack` with `count` != 0.
- Push and pop in the same cycle leave `count` unchanged; both pointers advance and wrap modulo `DEPTH`.
- Full with a same-cycle pop: push is still blocked, because `full` is evaluated from the registered `count`.
- Orphan response (`s_recv` while `count` == 0):
  - `s_ack` = 1 to drain it; both masters' recv = 0; no pop.
  - `rsp_orphan` = 1 on the next cycle.
- Reset (`g_reset` high at a clock edge, including mid-transaction):
  - `count`, pointers and `rsp_orphan` return to 0; `last` returns to 1, so master 0 wins the first tie.
  - Outstanding IDs are discarded; a later response for a discarded ID is treated as orphan.

## Timing
- Request path (`mX_*` to `s_*`) and grant path (`s_gnt` to `mX_gnt`): 0-cycle combinational.
- Response path (`s_recv`/`s_rdata` to `mX_*`, and `mX_ack` to `s_ack`): 0-cycle combinational.
- Arbitration priority change, FIFO push/pop and the resulting `count`: visible the cycle after the handshake.
- Throughput: one grant per cycle. Back-to-back grants to the same master are allowed when the other master is idle.
- Reset values: `s_req` = 0 and all gnt/recv = 0 while no requests or responses are presented; `s_ack` = 0; `rsp_orphan` = 0.

## Test plan
- Single master: `m1_req` with addr 0x100 and `s_gnt`=1 → `m1_gnt`=1 the same cycle. Then `s_recv`=1, `s_rdata`=0xDEADBEEF → `m1_recv`=1, `m1_rdata`=0xDEADBEEF, `m0_recv`=0.
- Contention: both masters hold req with `s_gnt`=1 for 4 cycles after reset → grants alternate m0, m1, m0, m1. With `s_gnt`=0, no grant and `last` is unchanged.
- Ordering: grant m0, m1, m0 with no responses, then three responses → recv routed to m0, m1, m0 in that order. Holding `m1_ack`=0 keeps `s_ack`=0 and the FIFO head unchanged.
- Full and wrap (`DEPTH`=4): 4 grants without response → `s_req`=0 while full. With a response popped in the full cycle, no push that cycle; the next push succeeds. Run 10 push/pop pairs to exercise pointer wrap.
- Orphan: `s_recv`=1 with an empty FIFO → `s_ack`=1, no master recv, `rsp_orphan`=1 for exactly one cycle.
- Reset mid-operation: 2 outstanding, assert `g_reset` for 1 cycle → `count`=0. The next tie grants m0. The stale response flags `rsp_orphan`.
